// File: rtl/uart_tx_param.sv
// Parameterized UART transmitter: start bit, DATA_BITS LSB-first, optional parity, 1-2 stop bits.
// Registered serial line, zero-latency start on acceptance, one-cycle done pulse in the first idle cycle.
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 enable,
  output logic                 ready,
  output logic                 data_bit,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
  endgenerate

  logic [2:0]           state;
  logic [CW-1:0]        clk_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 bit_end;

  assign bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign ready   = (state == S_IDLE);
  assign busy    = ~ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      data_bit <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        // Start bit goes out on the accepting edge itself.
        if (enable) begin
          state    <= S_START;
          shreg    <= data;
          par_bit  <= (^data) ^ (PARITY_MODE == 2);
          data_bit <= 1'b0;
          clk_cnt  <= '0;
          bit_idx  <= '0;
        end
      end else begin
        if (bit_end) clk_cnt <= '0;
        else         clk_cnt <= clk_cnt + CW'(1);

        if (bit_end) begin
          case (state)
            S_START: begin
              state    <= S_DATA;
              data_bit <= shreg[0];
              shreg    <= shreg >> 1;
              bit_idx  <= '0;
            end
            S_DATA: begin
              if (bit_idx == 4'(DATA_BITS - 1)) begin
                bit_idx <= '0;
                if (PARITY_MODE != 0) begin
                  state    <= S_PARITY;
                  data_bit <= par_bit;
                end else begin
                  state    <= S_STOP;
                  data_bit <= 1'b1;
                end
              end else begin
                bit_idx  <= bit_idx + 4'd1;
                data_bit <= shreg[0];
                shreg    <= shreg >> 1;
              end
            end
            S_PARITY: begin
              state    <= S_STOP;
              data_bit <= 1'b1;
              bit_idx  <= '0;
            end
            S_STOP: begin
              if (bit_idx == 4'(STOP_BITS - 1)) begin
                state   <= S_IDLE;
                done    <= 1'b1;
                bit_idx <= '0;
              end else begin
                bit_idx <= bit_idx + 4'd1;
              end
            end
            default: begin
              state    <= S_IDLE;
              data_bit <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule
